// File: rtl/isqrt_pkg.sv
// Shared types and constants for the sequential integer square-root block.
// Holds the controller state encoding and the per-mode root limits.
package isqrt_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Largest root allowed in unsigned mode: 2^w - 1.
    function automatic int umax(input int w);
        return (1 << w) - 1;
    endfunction

    // Largest root allowed in signed mode: 2^(w-1).
    function automatic int smax(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/isqrt_seq_sq_table.sv
// Combinational square lookup: W-bit operand to its 2*W-bit square.
// Built as a constant table indexed by the operand, not as a multiplier.
module sq_table #(
    parameter int W = 4
) (
    input  logic [W-1:0]   x,
    output logic [2*W-1:0] sq
);

    // Table lookup over every representable operand value.
    always_comb begin
        sq = {(2*W){1'b0}};
        for (int i = 0; i < (1 << W); i++) begin
            if (x == W'(i)) begin
                sq = (2*W)'(i * i);
            end else begin
                sq = sq;
            end
        end
    end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential integer square root: walks the candidate up from zero one step
// per cycle until its successor would overshoot the value or the mode limit.
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] value,
    input  logic           sign,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   root,
    output logic [2*W-1:0] rem,
    output logic           exact,
    output logic           err
);

    localparam logic [W:0]     UMAX_C    = (W+1)'(umax(W));
    localparam logic [W:0]     SMAX_C    = (W+1)'(smax(W));
    localparam logic [2*W-1:0] SMAX_SQ_C = (2*W)'(1) << (2*W - 2);

    state_t         state_r;
    logic [W-1:0]   cand_r;
    logic [2*W-1:0] cand_sq_r;
    logic [2*W-1:0] value_r;
    logic           sign_r;
    logic           busy_r;
    logic           done_r;
    logic [W-1:0]   root_r;
    logic [2*W-1:0] rem_r;
    logic           exact_r;
    logic           err_r;

    logic [W:0]     next_s;
    logic [2*W-1:0] next_sq_s;
    logic [W:0]     limit_s;
    logic           stop_s;

    // next is one bit wider so the step past 2^W-1 is seen as over-limit.
    assign next_s  = {1'b0, cand_r} + (W+1)'(1);
    assign limit_s = sign_r ? SMAX_C : UMAX_C;
    assign stop_s  = (next_s > limit_s) || (next_sq_s > value_r);

    sq_table #(.W(W)) u_sq_table (
        .x  (next_s[W-1:0]),
        .sq (next_sq_s)
    );

    // Controller and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cand_r    <= {W{1'b0}};
            cand_sq_r <= {(2*W){1'b0}};
            value_r   <= {(2*W){1'b0}};
            sign_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            root_r    <= {W{1'b0}};
            rem_r     <= {(2*W){1'b0}};
            exact_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r   <= SEARCH;
                        busy_r    <= 1'b1;
                        value_r   <= value;
                        sign_r    <= sign;
                        cand_r    <= {W{1'b0}};
                        cand_sq_r <= {(2*W){1'b0}};
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (stop_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        root_r  <= cand_r;
                        rem_r   <= value_r - cand_sq_r;
                        exact_r <= (value_r == cand_sq_r);
                        err_r   <= sign_r && (value_r > SMAX_SQ_C);
                    end else begin
                        cand_r    <= next_s[W-1:0];
                        cand_sq_r <= next_sq_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign root  = root_r;
    assign rem   = rem_r;
    assign exact = exact_r;
    assign err   = err_r;

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq (W=4): directed corner cases plus random
// searches compared against an arithmetic square-root reference.
module tb_isqrt_seq;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [2*W-1:0] value;
    logic           sign;
    logic           busy;
    logic           done;
    logic [W-1:0]   root;
    logic [2*W-1:0] rem;
    logic           exact;
    logic           err;

    int n_checks = 0;
    int n_pass   = 0;

    isqrt_seq #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .sign  (sign),
        .busy  (busy),
        .done  (done),
        .root  (root),
        .rem   (rem),
        .exact (exact),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: largest n in the mode range with n*n <= v, found top-down.
    function automatic int ref_root(input int v, input bit s);
        int lim;
        lim = s ? (1 << (W - 1)) : ((1 << W) - 1);
        for (int n = lim; n >= 0; n--) begin
            if (n * n <= v) return n;
        end
        return 0;
    endfunction

    // Wait for done after acceptance edge; cycle index is edges-since-T plus one.
    task automatic wait_done(input string tag, input int v, input bit s, input bit pulse);
        int k;
        int r;
        bit seen;
        r = ref_root(v, s);
        k = 0;
        seen = 1'b0;
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        while (!seen && k < 40) begin
            @(posedge clk);
            k++;
            #1;
            if (pulse && k == 1) begin
                start = 1'b1;
                value = 8'd1;
                sign  = 1'b1;
            end else if (pulse && k == 2) begin
                start = 1'b0;
            end else begin
                start = start;
            end
            if (done) seen = 1'b1;
        end
        chk({tag, ".seen"}, {31'd0, seen}, 32'd1);
        chk({tag, ".lat"}, k + 1, r + 2);
        chk({tag, ".root"}, {28'd0, root}, r);
        chk({tag, ".rem"}, {24'd0, rem}, v - r * r);
        chk({tag, ".exact"}, {31'd0, exact}, (v == r * r) ? 32'd1 : 32'd0);
        chk({tag, ".err"}, {31'd0, err}, (s && v > 64) ? 32'd1 : 32'd0);
    endtask

    task automatic run(input string tag, input int v, input bit s, input bit pulse);
        @(negedge clk);
        start = 1'b1;
        value = 8'(v);
        sign  = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(tag, v, s, pulse);
    endtask

    initial begin
        int v;
        bit s;
        rst   = 1'b1;
        start = 1'b0;
        value = 8'd0;
        sign  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.root", {28'd0, root}, 32'd0);
        chk("rst.rem", {24'd0, rem}, 32'd0);
        chk("rst.exact", {31'd0, exact}, 32'd0);
        chk("rst.err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        run("u49", 49, 1'b0, 1'b0);
        run("u50", 50, 1'b0, 1'b0);
        run("u255", 255, 1'b0, 1'b0);
        run("s100", 100, 1'b1, 1'b0);
        run("s64", 64, 1'b1, 1'b0);
        run("u0", 0, 1'b0, 1'b0);
        run("u200mid", 200, 1'b0, 1'b1);

        // Results and done hold/drop correctly while idle.
        repeat (3) @(posedge clk);
        #1;
        chk("hold.done", {31'd0, done}, 32'd0);
        chk("hold.root", {28'd0, root}, 32'd14);
        chk("hold.rem", {24'd0, rem}, 32'd4);

        // Reset mid-search, with start asserted during reset.
        @(negedge clk);
        start = 1'b1;
        value = 8'd200;
        sign  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b1;
        value = 8'd9;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("mrst.busy", {31'd0, busy}, 32'd0);
        chk("mrst.done", {31'd0, done}, 32'd0);
        chk("mrst.root", {28'd0, root}, 32'd0);
        chk("mrst.rem", {24'd0, rem}, 32'd0);
        begin
            int cnt;
            cnt = 0;
            repeat (20) begin
                @(posedge clk);
                #1;
                if (done || busy) cnt++;
            end
            chk("mrst.quiet", cnt, 32'd0);
        end

        // Back-to-back: start held through DONE.
        @(negedge clk);
        start = 1'b1;
        value = 8'd9;
        sign  = 1'b0;
        @(posedge clk);
        #1;
        wait_done("b2b9", 9, 1'b0, 1'b0);
        value = 8'd16;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b.nodone", {31'd0, done}, 32'd0);
        wait_done("b2b16", 16, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            v = int'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            run("rand", v, s, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
